// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Responder end of the simple memory bus. It holds a 2**AW x DW register-file
// memory and accepts one write and/or one read request on every clock. Read
// data is registered, so it appears one clock after the request, and it comes
// with a one-cycle valid strobe. Each entry has a written flag, which lets the
// block report reads of locations that have not been written since reset.
//
// Optional feature: MEM_RESPONDER_WR_BYPASS_EN
//   defined   : write-first. A read in the same cycle as a write returns the
//               new write data, with unwritten_err = 0.
//   undefined : read-first. That read returns the pre-write contents, and
//               unwritten_err reflects the pre-write flag.
//
// Ports
//   clk           in   system clock, all logic on posedge
//   RESET         in   synchronous, active-high reset
//   address       in   [AW-1:0] request address, shared by read and write
//   data          in   [DW-1:0] write data
//   write         in   write request
//   read          in   read request
//   data_out      out  [DW-1:0] registered read data, holds between reads
//   valid_out     out  one-cycle strobe: data_out updated by a read
//   unwritten_err out  one-cycle strobe with valid_out: entry never written
//   wr_count      out  [AW:0] number of distinct entries written since reset
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int AW = 3,
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] data,
    input  logic          write,
    input  logic          read,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    output logic          unwritten_err,
    output logic [AW:0]   wr_count
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] flag_q, flag_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;

    logic             rd_flag;
    logic [DW-1:0]    rd_word;

    always_comb begin
        mem_d   = mem_q;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        rd_flag = flag_q[address];
        rd_word = mem_q[address];

        if (read) begin
            vld_d = 1'b1;
`ifdef MEM_RESPONDER_WR_BYPASS_EN
            // The address is shared, so a concurrent write always hits the
            // entry being read: forward the incoming data.
            if (write) begin
                dout_d = data;
                err_d  = 1'b0;
            end else begin
                dout_d = rd_flag ? rd_word : '0;
                err_d  = ~rd_flag;
            end
`else
            // Pre-write view of the entry, even when it is written this cycle.
            dout_d = rd_flag ? rd_word : '0;
            err_d  = ~rd_flag;
`endif
        end

        if (write) begin
            mem_d[address] = data;
            // Count only the first write to each entry, so the counter
            // saturates naturally at DEPTH.
            if (!flag_q[address]) begin
                flag_d[address] = 1'b1;
                cnt_d           = cnt_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            flag_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end

    assign data_out      = dout_q;
    assign valid_out     = vld_q;
    assign unwritten_err = err_q;
    assign wr_count      = cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic       clk;
    logic       RESET;
    logic [2:0] address;
    logic [5:0] data;
    logic       write;
    logic       read;
    logic [5:0] data_out;
    logic       valid_out;
    logic       unwritten_err;
    logic [3:0] wr_count;

    int checks;
    int errors;

    // Reference model: contents and written status per location, plus the
    // expected output values after the most recent clock.
    logic [5:0] m_mem  [8];
    bit         m_done [8];
    logic [5:0] m_do;
    logic       m_vld;
    logic       m_err;

    mem_responder #(.AW(3), .DW(6)) dut (
        .clk           (clk),
        .RESET         (RESET),
        .address       (address),
        .data          (data),
        .write         (write),
        .read          (read),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .unwritten_err (unwritten_err),
        .wr_count      (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] m_count();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m_done[i]) n++;
        return 4'(n);
    endfunction

    // Drive one request for one clock, update the model, and return at #1
    // after the edge where the registered outputs reflect the request.
    task automatic cyc(input logic r, input logic w, input logic rd,
                       input logic [2:0] a, input logic [5:0] d);
        RESET = r; write = w; read = rd; address = a; data = d;
        if (r) begin
            for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_done[i] = 0; end
            m_do = '0; m_vld = 1'b0; m_err = 1'b0;
        end else begin
            m_vld = rd;
            m_err = 1'b0;
            if (rd) begin
`ifdef MEM_RESPONDER_WR_BYPASS_EN
                if (w) begin
                    m_do = d;
                    m_err = 1'b0;
                end else begin
                    m_do  = m_done[a] ? m_mem[a] : 6'd0;
                    m_err = !m_done[a];
                end
`else
                m_do  = m_done[a] ? m_mem[a] : 6'd0;
                m_err = !m_done[a];
`endif
            end
            if (w) begin m_mem[a] = d; m_done[a] = 1; end
        end
        @(posedge clk);
        #1;
        RESET = 1'b0; write = 1'b0; read = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1, 0, 1, 3'd3, 6'd0);
        checks++; if (data_out !== 6'd0) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
        checks++; if (unwritten_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", unwritten_err); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", wr_count); end
    endtask

    task automatic fill();
        cyc(1, 0, 0, 3'd0, 6'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 3'(i), 6'(i + 1));
            checks++; if (wr_count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, wr_count, i + 1); end
            checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL fill_valid[%0d] got %b want 0", i, valid_out); end
        end
    endtask

    task automatic test_fill_readback();
        fill();
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 3'(i), 6'h3F);
            checks++; if (data_out !== 6'(i + 1)) begin errors++; $display("FAIL seq_data[%0d] got %h want %h", i, data_out, 6'(i + 1)); end
            checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b want 1", i, valid_out); end
            checks++; if (unwritten_err !== 1'b0) begin errors++; $display("FAIL seq_err[%0d] got %b want 0", i, unwritten_err); end
        end
        checks++; if (wr_count !== 4'd8) begin errors++; $display("FAIL seq_count got %0d want 8", wr_count); end
    endtask

    task automatic test_scattered();
        int addrs [8] = '{3, 4, 1, 0, 0, 7, 5, 7};
        int exps  [8] = '{4, 5, 2, 1, 1, 8, 6, 8};
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 3'(addrs[i]), 6'd0);
            checks++; if (data_out !== 6'(exps[i]) || valid_out !== 1'b1) begin
                errors++; $display("FAIL scatter[%0d] got %h/%b want %h/1", i, data_out, valid_out, 6'(exps[i]));
            end
        end
    endtask

    task automatic test_unwritten();
        cyc(1, 0, 0, 3'd0, 6'd0);
        cyc(0, 1, 0, 3'd2, 6'h2A);
        cyc(0, 0, 1, 3'd5, 6'h11);
        checks++; if (data_out !== 6'd0) begin errors++; $display("FAIL unwr_data got %h want 00", data_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL unwr_valid got %b want 1", valid_out); end
        checks++; if (unwritten_err !== 1'b1) begin errors++; $display("FAIL unwr_err got %b want 1", unwritten_err); end
        checks++; if (wr_count !== 4'd1) begin errors++; $display("FAIL unwr_count got %0d want 1", wr_count); end
        cyc(0, 0, 0, 3'd0, 6'd0);
        checks++; if (unwritten_err !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL unwr_strobe_drop got %b/%b want 0/0", valid_out, unwritten_err); end
        cyc(0, 1, 0, 3'd2, 6'h15);
        checks++; if (wr_count !== 4'd1) begin errors++; $display("FAIL rewrite_count got %0d want 1", wr_count); end
        cyc(0, 0, 1, 3'd2, 6'd0);
        checks++; if (data_out !== 6'h15 || unwritten_err !== 1'b0) begin errors++; $display("FAIL rewrite_data got %h/%b want 15/0", data_out, unwritten_err); end
    endtask

    task automatic test_collision();
        logic [5:0] first_exp;
`ifdef MEM_RESPONDER_WR_BYPASS_EN
        first_exp = 6'h3F;
`else
        first_exp = 6'h08;
`endif
        fill();
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 3'd7, 6'h3F);
            checks++; if (data_out !== ((k == 0) ? first_exp : 6'h3F) || valid_out !== 1'b1 || unwritten_err !== 1'b0) begin
                errors++; $display("FAIL collide[%0d] got %h/%b/%b want %h/1/0", k, data_out, valid_out, unwritten_err, (k == 0) ? first_exp : 6'h3F);
            end
        end
        cyc(0, 0, 1, 3'd7, 6'd0);
        checks++; if (data_out !== 6'h3F) begin errors++; $display("FAIL collide_mem got %h want 3f", data_out); end
        checks++; if (wr_count !== 4'd8) begin errors++; $display("FAIL collide_count got %0d want 8", wr_count); end
        // Collision on an unwritten entry: the flag policy differs per build.
        cyc(1, 0, 0, 3'd0, 6'd0);
        cyc(0, 1, 1, 3'd4, 6'h27);
`ifdef MEM_RESPONDER_WR_BYPASS_EN
        checks++; if (data_out !== 6'h27 || unwritten_err !== 1'b0) begin errors++; $display("FAIL collide_new got %h/%b want 27/0", data_out, unwritten_err); end
`else
        checks++; if (data_out !== 6'h00 || unwritten_err !== 1'b1) begin errors++; $display("FAIL collide_new got %h/%b want 00/1", data_out, unwritten_err); end
`endif
    endtask

    task automatic test_reset_mid();
        fill();
        cyc(0, 0, 1, 3'd6, 6'd0);
        cyc(1, 1, 0, 3'd0, 6'h0B);
        checks++; if (data_out !== 6'd0 || valid_out !== 1'b0 || unwritten_err !== 1'b0 || wr_count !== 4'd0) begin
            errors++; $display("FAIL midreset_outs got %h/%b/%b/%0d want 00/0/0/0", data_out, valid_out, unwritten_err, wr_count);
        end
        cyc(0, 0, 1, 3'd0, 6'd0);
        checks++; if (data_out !== 6'd0 || valid_out !== 1'b1 || unwritten_err !== 1'b1) begin
            errors++; $display("FAIL midreset_read got %h/%b/%b want 00/1/1", data_out, valid_out, unwritten_err);
        end
    endtask

    task automatic test_idle_hold();
        cyc(0, 1, 0, 3'd1, 6'h02);
        cyc(0, 0, 1, 3'd1, 6'd0);
        checks++; if (data_out !== 6'h02) begin errors++; $display("FAIL idle_read got %h want 02", data_out); end
        for (int i = 0; i < 5; i++) begin
            address = 3'($urandom); data = 6'($urandom);
            cyc(0, 0, 0, 3'($urandom), 6'($urandom));
            checks++; if (data_out !== 6'h02 || valid_out !== 1'b0 || unwritten_err !== 1'b0) begin
                errors++; $display("FAIL idle[%0d] got %h/%b/%b want 02/0/0", i, data_out, valid_out, unwritten_err);
            end
        end
    endtask

    task automatic test_random();
        cyc(1, 0, 0, 3'd0, 6'd0);
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                3'($urandom), 6'($urandom));
            checks++; if (data_out !== m_do || valid_out !== m_vld || unwritten_err !== m_err || wr_count !== m_count()) begin
                errors++;
                $display("FAIL random[%0d] got %h/%b/%b/%0d want %h/%b/%b/%0d", n, data_out, valid_out,
                         unwritten_err, wr_count, m_do, m_vld, m_err, m_count());
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        RESET = 1'b1; write = 1'b0; read = 1'b0; address = '0; data = '0;
        for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_done[i] = 0; end
        m_do = '0; m_vld = 1'b0; m_err = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_readback();
        test_scattered();
        test_unwritten();
        test_collision();
        test_reset_mid();
        test_idle_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
